// File: rtl/serial_cmp_pkg.sv
// Shared types for the serial comparator: FSM state encoding and the
// one-hot {GT,EQ,LT} result encoding.
package serial_cmp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef logic [2:0] res_t;

    localparam res_t RES_NONE = 3'b000;
    localparam res_t RES_GT   = 3'b100;
    localparam res_t RES_EQ   = 3'b010;
    localparam res_t RES_LT   = 3'b001;

endpackage

// File: rtl/serial_cmp_cmp2_slice.sv
// Combinational magnitude compare of one 2-bit slice; exactly one output is high.
module cmp2_slice (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic       gt,
    output logic       eq,
    output logic       lt
);

    assign gt = (a > b);
    assign eq = (a == b);
    assign lt = (a < b);

endmodule

// File: rtl/serial_cmp.sv
// Serial MSB-first comparator, two bits per cycle with early exit on the first
// differing slice. Define SERIAL_CMP_SIGNED_EN for a two's-complement compare.
module serial_cmp
    import serial_cmp_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] inA,
    input  logic [WIDTH-1:0] inB,
    output logic             busy,
    output logic             done,
    output logic             outGT,
    output logic             outEQ,
    output logic             outLT
);

    localparam int N     = WIDTH / 2;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(N - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    res_t             res_q, res_d;
    logic [WIDTH-1:0] a_q, b_q;
    logic             load;
    logic [1:0]       a_sl, b_sl;
    logic             sl_gt, sl_eq, sl_lt;

    always_comb begin
        a_sl = a_q[2*int'(idx_q) +: 2];
        b_sl = b_q[2*int'(idx_q) +: 2];
`ifdef SERIAL_CMP_SIGNED_EN
        // Flipping both sign bits maps two's-complement order onto unsigned order.
        if (idx_q == IDX_MSB) begin
            a_sl[1] = ~a_sl[1];
            b_sl[1] = ~b_sl[1];
        end
`endif
    end

    cmp2_slice u_slice (
        .a  (a_sl),
        .b  (b_sl),
        .gt (sl_gt),
        .eq (sl_eq),
        .lt (sl_lt)
    );

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d = state_q;
        idx_d   = idx_q;
        res_d   = res_q;
        load    = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    load    = 1'b1;
                    idx_d   = IDX_MSB;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (sl_gt) begin
                    res_d   = RES_GT;
                    state_d = DONE;
                end else if (sl_lt) begin
                    res_d   = RES_LT;
                    state_d = DONE;
                end else if (idx_q == '0) begin
                    res_d   = RES_EQ;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            res_q   <= RES_NONE;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            res_q   <= res_d;
        end
    end

    // NOTE: operand latches carry no reset; they are always reloaded before being read.
    always_ff @(posedge clk) begin
        if (load) begin
            a_q <= inA;
            b_q <= inB;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign {outGT, outEQ, outLT} = res_q;

endmodule

// File: tb/tb_serial_cmp.sv
// Self-checking bench for serial_cmp (WIDTH=8): directed vectors plus randomized
// compares against a whole-word reference model.
module tb_serial_cmp;
    import serial_cmp_pkg::*;

    localparam int W = 8;
    localparam int N = W / 2;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] inA = '0;
    logic [W-1:0] inB = '0;
    logic         busy, done, outGT, outEQ, outLT;

    int   n_checks = 0;
    int   n_fail   = 0;
    res_t last_res = RES_NONE;

    serial_cmp #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .inA   (inA),
        .inB   (inB),
        .busy  (busy),
        .done  (done),
        .outGT (outGT),
        .outEQ (outEQ),
        .outLT (outLT)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    // Reference: relation from whole-word arithmetic; k = slices scanned MSB-first
    // up to and including the first differing one.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output res_t r, output int k);
        k = 0;
        for (int i = N - 1; i >= 0; i--) begin
            k++;
            if (a[2*i +: 2] != b[2*i +: 2]) break;
        end
`ifdef SERIAL_CMP_SIGNED_EN
        if ($signed(a) > $signed(b))      r = RES_GT;
        else if ($signed(a) < $signed(b)) r = RES_LT;
        else                              r = RES_EQ;
`else
        if (a > b)      r = RES_GT;
        else if (a < b) r = RES_LT;
        else            r = RES_EQ;
`endif
    endfunction

    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        inA   = a;
        inB   = b;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Walks the cycles after a start-accepting edge; optionally pulses an ignored
    // start in the first RUN cycle, or chains a new start during DONE.
    task automatic observe(input string name, input res_t exp, input int k,
                           input bit inject, input bit chain,
                           input logic [W-1:0] na, input logic [W-1:0] nb);
        res_t got, want;
        for (int j = 0; j <= k; j++) begin
            @(negedge clk);
            got  = {outGT, outEQ, outLT};
            want = (j < k) ? last_res : exp;
            n_checks++;
            if (busy !== (j < k)) begin
                n_fail++;
                $display("FAIL %s busy cycle %0d: got %b want %b", name, j, busy, (j < k));
            end
            n_checks++;
            if (done !== (j == k)) begin
                n_fail++;
                $display("FAIL %s done cycle %0d: got %b want %b", name, j, done, (j == k));
            end
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL %s result cycle %0d: got %b want %b", name, j, got, want);
            end
            if (inject && j == 0) begin
                start = 1'b1;
                inA   = 8'hFF;
                inB   = 8'h00;
            end
            if (inject && j == 1) start = 1'b0;
            if (chain && j == k) begin
                start = 1'b1;
                inA   = na;
                inB   = nb;
            end
        end
        last_res = exp;
        if (chain) begin
            @(posedge clk);
            #1 start = 1'b0;
        end else begin
            @(negedge clk);
            got = {outGT, outEQ, outLT};
            n_checks++;
            if (busy !== 1'b0 || done !== 1'b0 || got !== exp) begin
                n_fail++;
                $display("FAIL %s idle after done: got busy=%b done=%b res=%b want 0 0 %b",
                         name, busy, done, got, exp);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b1;
        inA   = 8'h12;
        inB   = 8'h34;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({busy, done, outGT, outEQ, outLT} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_state: got %b want 00000", {busy, done, outGT, outEQ, outLT});
        end
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({busy, done, outGT, outEQ, outLT} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_release: got %b want 00000", {busy, done, outGT, outEQ, outLT});
        end
        last_res = RES_NONE;
    endtask

    task automatic test_directed();
        launch(8'hA5, 8'hA5);
        observe("eq_a5", RES_EQ, 4, 1'b0, 1'b0, '0, '0);
        launch(8'h80, 8'h7F);
`ifdef SERIAL_CMP_SIGNED_EN
        observe("signed_80_7f", RES_LT, 1, 1'b0, 1'b0, '0, '0);
`else
        observe("unsigned_80_7f", RES_GT, 1, 1'b0, 1'b0, '0, '0);
`endif
        launch(8'h34, 8'h35);
        observe("lt_lsb", RES_LT, 4, 1'b0, 1'b0, '0, '0);
        launch(8'h34, 8'h24);
        observe("gt_slice2", RES_GT, 2, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic test_busy_ignore();
        launch(8'h10, 8'h20);
        observe("start_while_busy", RES_LT, 2, 1'b1, 1'b0, '0, '0);
    endtask

    task automatic test_reset_abort();
        launch(8'h34, 8'h35);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({busy, done, outGT, outEQ, outLT} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_abort: got %b want 00000", {busy, done, outGT, outEQ, outLT});
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_abort_quiet cycle %0d: got busy=%b done=%b want 0 0", i, busy, done);
            end
        end
        last_res = RES_NONE;
    endtask

    task automatic test_back_to_back();
        launch(8'h34, 8'h24);
        observe("b2b_first", RES_GT, 2, 1'b0, 1'b1, 8'h34, 8'h35);
        observe("b2b_second", RES_LT, 4, 1'b0, 1'b0, '0, '0);
    endtask

    function automatic logic [W-1:0] pick_b(input logic [W-1:0] a);
        logic [W-1:0] flip;
        case ($urandom_range(0, 2))
            0:       pick_b = a;
            1: begin
                flip   = W'($urandom_range(1, 3)) << (2 * $urandom_range(0, N - 1));
                pick_b = a ^ flip;
            end
            default: pick_b = W'($urandom);
        endcase
    endfunction

    task automatic test_random();
        logic [W-1:0] a, b, na, nb;
        res_t exp;
        int   k;
        bit   chain;
        bit   pending = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (!pending) begin
                a = W'($urandom);
                b = pick_b(a);
                launch(a, b);
            end else begin
                a = na;
                b = nb;
            end
            model(a, b, exp, k);
            chain = (i < 59) && ($urandom_range(0, 1) == 1);
            na    = W'($urandom);
            nb    = pick_b(na);
            observe("random", exp, k, 1'b0, chain, na, nb);
            pending = chain;
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_busy_ignore();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_cmp.md
SERIAL_CMP -- requirements
Module: serial_cmp

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits; even, >= 2; N = WIDTH/2 two-bit slices.
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port start, input, 1, request to load inA/inB and begin a compare.
REQ-005 SHALL have ports inA and inB, each input, WIDTH, operands, sampled only on the edge that accepts start.
REQ-006 SHALL have port busy, output, 1, high while a compare is in progress.
REQ-007 SHALL have port done, output, 1, one-cycle pulse marking a new valid result.
REQ-008 SHALL have ports outGT, outEQ and outLT, each output, 1, registered A>B / A==B / A<B result, held until the next completion.

Function
REQ-009 SHALL implement FSM states IDLE, RUN and DONE; busy = (state==RUN); done = (state==DONE).
REQ-010 IDLE or DONE with start=1 SHALL at the edge latch inA/inB, set slice index idx=N-1 and go to RUN; otherwise DONE SHALL go to IDLE.
REQ-011 start while in RUN SHALL be ignored; latched operands are unchanged.
REQ-012 Each RUN edge SHALL compare slice A[2*idx+1:2*idx] against B[2*idx+1:2*idx] (MSB slice first) with a 2-bit GT/EQ/LT compare.
REQ-013 Slice GT or LT SHALL end the compare early: outputs set one-hot to that relation, state goes to DONE.
REQ-014 Slice EQ with idx>0 SHALL decrement idx and stay in RUN; slice EQ with idx==0 SHALL set outEQ=1, others 0, and go to DONE.
REQ-015 Latency: done SHALL be high exactly k edges after the start-accepting edge, where k = number of slices examined (1..N); throughput at most one compare per k+1 cycles.
REQ-016 outGT/outEQ/outLT SHALL change only on the edge entering DONE or on reset; exactly one is high after the first completion.
REQ-017 start in the DONE cycle SHALL be accepted (back-to-back); done still pulses for exactly one cycle.

Reset
REQ-018 reset=1 SHALL at the edge force IDLE, busy=0, done=0, outGT=0, outEQ=0, outLT=0 and idx=0, regardless of state or start.
REQ-019 reset during RUN SHALL abort the compare; no done pulse is produced for it.

Configuration
REQ-020 Macro SERIAL_CMP_SIGNED_EN defined SHALL make the compare two's-complement: on the MSB slice only, bit 1 of both A and B slices is inverted before comparing.
REQ-021 Without SERIAL_CMP_SIGNED_EN the compare SHALL be unsigned; timing and interface are identical in both builds.

Structure
REQ-022 Package serial_cmp_pkg SHALL hold the state encoding constants (IDLE, RUN, DONE) and the 3-bit result encoding {GT,EQ,LT}.
REQ-023 The per-slice compare SHALL be a combinational sub-module cmp2_slice (2-bit A, 2-bit B in; GT, EQ, LT out), instantiated once and muxed by idx.
REQ-024 FSM, idx counter and result registers SHALL reside in serial_cmp.

Verification (WIDTH=8, N=4)
REQ-025 A=0xA5, B=0xA5, start one cycle: busy high 4 cycles, done high on the 4th edge after start, outEQ=1.
REQ-026 A=0x80, B=0x7F: unsigned build gives done 1 edge after start with outGT=1; SERIAL_CMP_SIGNED_EN build gives outLT=1 with the same timing.
REQ-027 A=0x34, B=0x35: done 4 edges after start, outLT=1. A=0x34, B=0x24: done 2 edges after start, outGT=1.
REQ-028 Start A=0x10, B=0x20, then start with A=0xFF, B=0x00 on the next cycle (while busy): second start ignored, result outLT=1.
REQ-029 reset asserted in the 2nd RUN cycle: next cycle busy=0, done=0, outputs all 0; no done pulse follows.
REQ-030 start held high during the DONE cycle with new operands: the new compare begins immediately, the prior result is visible during DONE, and two separate done pulses are observed.
